// File: rtl/pll_supervisor_if.sv
// Board-facing signals of the PLL supervisor: PLL reset/lock, re-lock button,
// downstream reset and status LEDs.
interface pll_supervisor_if;
  logic pll_LOCKED;
  logic btn1;
  logic pll_RSTN;
  logic sys_RSTN;
  logic led1;
  logic led2;

  modport master (
    input  pll_LOCKED,
    input  btn1,
    output pll_RSTN,
    output sys_RSTN,
    output led1,
    output led2
  );

  modport slave (
    output pll_LOCKED,
    output btn1,
    input  pll_RSTN,
    input  sys_RSTN,
    input  led1,
    input  led2
  );
endinterface

// File: rtl/pll_supervisor.sv
// PLL reset/lock supervisor on the oscillator clock: pulses the PLL reset, qualifies
// lock, gates the downstream reset, retries, latches a fault; button forces re-lock.
module pll_supervisor #(
  parameter int RST_CYCLES      = 32,
  parameter int LOCK_TIMEOUT    = 65536,
  parameter int SETTLE_CYCLES   = 256,
  parameter int MAX_RETRY       = 3,
  parameter int DEBOUNCE_CYCLES = 4096,
  parameter int BLINK_CYCLES    = 8192
) (
  input  logic             osc_CLK,
  input  logic             osc_RSTN,
  pll_supervisor_if.master pll_if
);

  localparam int MAX_RL  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX = (MAX_RL > SETTLE_CYCLES) ? MAX_RL : SETTLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam int RTY_W   = $clog2(MAX_RETRY + 1);
  localparam int DEB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BLK_W   = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_LIMIT   = RTY_W'(MAX_RETRY);
  localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BLK_W-1:0] BLK_LAST    = BLK_W'(BLINK_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_SETTLE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t state_q, state_d;

  logic             lock_meta_q, lock_meta_d;
  logic             lock_s_q, lock_s_d;
  logic             btn_meta_q, btn_meta_d;
  logic             btn_s_q, btn_s_d;
  logic             deb_q, deb_d;
  logic             deb_prev_q, deb_prev_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [RTY_W-1:0] retry_inc;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_ph_q, blink_ph_d;
  logic             pll_rstn_q, pll_rstn_d;
  logic             sys_rstn_q, sys_rstn_d;
  logic             led1_q, led1_d;
  logic             led2_q, led2_d;
  logic             press;

  // Two-flop synchronizers, then a debouncer that flips only after an unbroken
  // run of samples disagreeing with the current level.
  always_comb begin
    lock_meta_d = pll_if.pll_LOCKED;
    lock_s_d    = lock_meta_q;
    btn_meta_d  = pll_if.btn1;
    btn_s_d     = btn_meta_q;
    deb_d       = deb_q;
    deb_prev_d  = deb_q;
    deb_cnt_d   = '0;
    if (btn_s_q != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d = btn_s_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  // Press is taken from registered levels so it acts one edge after the debounce flip.
  assign press     = deb_q & ~deb_prev_q;
  assign retry_inc = retry_q + RTY_W'(1);

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    if (press) begin
      state_d = S_RESET_PLL;
      retry_d = '0;
    end else begin
      unique case (state_q)
        S_RESET_PLL: begin
          if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (lock_s_q) begin
            state_d = S_SETTLE;
          end else if (cnt_q == LOCK_LAST) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RTY_LIMIT) ? S_FAULT : S_RESET_PLL;
          end
        end
        S_SETTLE: begin
          if (!lock_s_q) begin
            state_d = S_WAIT_LOCK;
          end else if (cnt_q == SETTLE_LAST) begin
            state_d = S_RUN;
            retry_d = '0;
          end
        end
        S_RUN: begin
          if (!lock_s_q) state_d = S_RESET_PLL;
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_RESET_PLL;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || press) begin
      cnt_d = '0;
    end else if (state_q inside {S_RESET_PLL, S_WAIT_LOCK, S_SETTLE}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Blink phase restarts only on a fresh attempt; it free-runs across SETTLE<->WAIT_LOCK.
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if ((state_q == S_RESET_PLL) && (state_d == S_WAIT_LOCK)) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (state_q inside {S_WAIT_LOCK, S_SETTLE}) begin
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end

    pll_rstn_d = state_d inside {S_WAIT_LOCK, S_SETTLE, S_RUN};
    sys_rstn_d = (state_d == S_RUN);
    led1_d     = (state_d == S_RUN);
    led2_d     = (state_d == S_FAULT) |
                 ((state_d inside {S_WAIT_LOCK, S_SETTLE}) & blink_ph_d);
  end

  always_ff @(posedge osc_CLK or negedge osc_RSTN) begin
    if (!osc_RSTN) begin
      state_q <= S_RESET_PLL;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge osc_CLK or negedge osc_RSTN) begin
    if (!osc_RSTN) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      btn_meta_q  <= 1'b0;
      btn_s_q     <= 1'b0;
      deb_q       <= 1'b0;
      deb_prev_q  <= 1'b0;
      deb_cnt_q   <= '0;
      cnt_q       <= '0;
      retry_q     <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      pll_rstn_q  <= 1'b0;
      sys_rstn_q  <= 1'b0;
      led1_q      <= 1'b0;
      led2_q      <= 1'b0;
    end else begin
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
      btn_meta_q  <= btn_meta_d;
      btn_s_q     <= btn_s_d;
      deb_q       <= deb_d;
      deb_prev_q  <= deb_prev_d;
      deb_cnt_q   <= deb_cnt_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      pll_rstn_q  <= pll_rstn_d;
      sys_rstn_q  <= sys_rstn_d;
      led1_q      <= led1_d;
      led2_q      <= led2_d;
    end
  end

  assign pll_if.pll_RSTN = pll_rstn_q;
  assign pll_if.sys_RSTN = sys_rstn_q;
  assign pll_if.led1     = led1_q;
  assign pll_if.led2     = led2_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Scoreboard bench for pll_supervisor: directed scenarios plus random lock/button
// traffic, compared every cycle against a behavioural model of the supervisor rules.
module tb_pll_supervisor;
  localparam int RC = 4;
  localparam int LT = 20;
  localparam int SC = 8;
  localparam int MR = 2;
  localparam int DC = 5;
  localparam int BC = 3;

  logic osc_CLK  = 1'b0;
  logic osc_RSTN = 1'b1;

  pll_supervisor_if pif ();

  pll_supervisor #(
    .RST_CYCLES     (RC),
    .LOCK_TIMEOUT   (LT),
    .SETTLE_CYCLES  (SC),
    .MAX_RETRY      (MR),
    .DEBOUNCE_CYCLES(DC),
    .BLINK_CYCLES   (BC)
  ) dut (
    .osc_CLK (osc_CLK),
    .osc_RSTN(osc_RSTN),
    .pll_if  (pif.master)
  );

  always #5 osc_CLK = ~osc_CLK;

  typedef enum int {M_RST, M_WAIT, M_SETTLE, M_RUN, M_FAULT} mphase_t;

  mphase_t  m_ph;
  int       m_t, m_retry, m_acq;
  bit       m_deb, m_press;
  bit       lq[$];
  bit       bq[$];
  bit       bwin[$];
  bit [3:0] exp_q[$];
  bit       started = 1'b0;
  int       n_cmp = 0;
  int       n_bad = 0;

  function automatic void model_reset();
    m_ph    = M_RST;
    m_t     = 0;
    m_retry = 0;
    m_acq   = 0;
    m_deb   = 1'b0;
    m_press = 1'b0;
    lq      = '{1'b0, 1'b0};
    bq      = '{1'b0, 1'b0};
    bwin.delete();
  endfunction

  // One clock edge of the supervisor as described by its rules; inputs are the
  // levels presented at this edge, seen by the decision logic two edges later.
  function automatic void model_step(input bit lock_in, input bit btn_in);
    bit      lock_seen, btn_seen, all_diff;
    mphase_t nx;
    lock_seen = lq.pop_front();
    lq.push_back(lock_in);
    btn_seen = bq.pop_front();
    bq.push_back(btn_in);
    nx = m_ph;
    if (m_ph == M_WAIT || m_ph == M_SETTLE) m_acq++;
    if (m_press) begin
      nx = M_RST;
      m_retry = 0;
    end else begin
      case (m_ph)
        M_RST:    if (m_t == RC - 1) nx = M_WAIT;
        M_WAIT: begin
          if (lock_seen) nx = M_SETTLE;
          else if (m_t == LT - 1) begin
            m_retry++;
            nx = (m_retry == MR) ? M_FAULT : M_RST;
          end
        end
        M_SETTLE: begin
          if (!lock_seen) nx = M_WAIT;
          else if (m_t == SC - 1) begin
            nx = M_RUN;
            m_retry = 0;
          end
        end
        M_RUN:    if (!lock_seen) nx = M_RST;
        default:  nx = m_ph;
      endcase
    end
    if (m_ph == M_RST && nx == M_WAIT) m_acq = 0;
    m_t  = (nx != m_ph || m_press) ? 0 : m_t + 1;
    m_ph = nx;
    bwin.push_back(btn_seen);
    if (bwin.size() > DC) void'(bwin.pop_front());
    all_diff = (bwin.size() == DC);
    foreach (bwin[i]) if (bwin[i] == m_deb) all_diff = 1'b0;
    m_press = all_diff && !m_deb;
    if (all_diff) m_deb = !m_deb;
  endfunction

  function automatic bit [3:0] model_out();
    bit acq, l2;
    acq = (m_ph == M_WAIT) || (m_ph == M_SETTLE);
    l2  = (m_ph == M_FAULT) || (acq && ((m_acq / BC) % 2 == 1));
    return {acq || (m_ph == M_RUN), m_ph == M_RUN, m_ph == M_RUN, l2};
  endfunction

  function automatic bit [3:0] dut_out();
    return {pif.pll_RSTN, pif.sys_RSTN, pif.led1, pif.led2};
  endfunction

  task automatic check(input string name, input bit [3:0] got, input bit [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got {pll_RSTN,sys_RSTN,led1,led2}=%b, expected %b",
               name, $time, got, exp);
    end
  endtask

  task automatic drive(input bit rstn, input bit lock, input bit btn);
    osc_RSTN       = rstn;
    pif.pll_LOCKED = lock;
    pif.btn1       = btn;
    if (!rstn) model_reset();
    else model_step(lock, btn);
    exp_q.push_back(model_out());
    started = 1'b1;
  endtask

  task automatic cycle(input bit rstn, input bit lock, input bit btn);
    @(negedge osc_CLK);
    drive(rstn, lock, btn);
  endtask

  task automatic async_pulse(input bit lock, input bit btn);
    @(negedge osc_CLK);
    #1;
    osc_RSTN = 1'b0;
    #1;
    check("async_reset", dut_out(), 4'b0000);
    model_reset();
    drive(1'b1, lock, btn);
  endtask

  // Monitor: one expected vector per clock edge, sampled just after the edge.
  initial begin
    wait (started);
    forever begin
      @(posedge osc_CLK);
      #1;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_empty @%0t: got %b, expected a queued entry", $time, dut_out());
      end else begin
        check("outputs", dut_out(), exp_q.pop_front());
      end
    end
  end

  initial begin
    pif.pll_LOCKED = 1'b0;
    pif.btn1       = 1'b0;
    model_reset();
    #1 osc_RSTN = 1'b0;
    #1 check("reset_state", dut_out(), 4'b0000);

    repeat (3) cycle(1'b0, 1'b0, 1'b0);

    // Power-up: release reset, lock arrives 10 cycles later.
    repeat (10) cycle(1'b1, 1'b0, 1'b0);
    repeat (30) cycle(1'b1, 1'b1, 1'b0);

    // Lock loss in RUN with quick recovery, then chatter during SETTLE.
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 50 && !(m_ph == M_SETTLE && m_t == 3); i++) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    repeat (25) cycle(1'b1, 1'b1, 1'b0);

    // Persistent loss: retries then FAULT held well over 200 cycles.
    repeat (260) cycle(1'b1, 1'b0, 1'b0);

    // Bounced press out of FAULT, release, re-lock to RUN.
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    repeat (15) cycle(1'b1, 1'b1, 1'b1);
    repeat (30) cycle(1'b1, 1'b1, 1'b0);

    // Asynchronous reset mid-RUN, power-up again.
    async_pulse(1'b1, 1'b0);
    repeat (30) cycle(1'b1, 1'b1, 1'b0);

    // Loss from RUN must still take the full retry count to reach FAULT.
    repeat (80) cycle(1'b1, 1'b0, 1'b0);

    // Random lock and button traffic.
    for (int seg = 0; seg < 120; seg++) begin
      bit lk;
      bit pr;
      int len;
      lk  = ($urandom_range(0, 9) < 7);
      pr  = ($urandom_range(0, 7) == 0);
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++)
        cycle(1'b1, lk, (pr && i < 12) ? ($urandom_range(0, 3) != 0) : 1'b0);
      if ($urandom_range(0, 30) == 0) async_pulse(lk, 1'b0);
    end

    @(posedge osc_CLK);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
